mem_stage: RTL

- Memory stage of the 16-bit pipelined core, directly downstream of the execute stage.
- Consumes the execute result, destination index, control and write-enable.
- Performs data-memory access for LOAD and STORE over a req/ready handshake, stalling execute while an access is outstanding.
- Presents a registered writeback/forwarding bundle to the writeback stage and back to decode.

---
 rtl/mem_stage.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 16-bit pipelined core.
// Accepts the execute bundle, performs LOAD/STORE over a req/ready handshake
// (stalling execute via ex_ready while an access is outstanding) and presents
// a registered writeback/forwarding bundle.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ex_valid, ex_control, ex_result,
//   ex_store_data, ex_dest, ex_wr_en  execute bundle in
//   ex_ready                        combinational; 1 when a bundle can be taken
//   mem_req, mem_we, mem_addr,
//   mem_wdata                       data-memory request (registered)
//   mem_rdata, mem_ready            data-memory response
//   wb_valid, wb_control, wb_dest,
//   wb_data, wb_wr_en               writeback bundle (registered)
//   bus_err                         one-cycle pulse on access timeout
module mem_stage #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DEST_W  = 6,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [4:0]        ex_control,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [DEST_W-1:0] ex_dest,
    input  logic              ex_wr_en,
    output logic              ex_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              wb_valid,
    output logic [4:0]        wb_control,
    output logic [DEST_W-1:0] wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_wr_en,
    output logic              bus_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b1100;
    localparam logic [3:0] OP_STORE = 4'b1110;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    logic [0:0]        state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [DEST_W-1:0] cap_dest_q, cap_dest_d;
    logic [4:0]        cap_ctrl_q, cap_ctrl_d;

    logic              mem_req_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              wb_valid_d, wb_wr_en_d, bus_err_d;
    logic [4:0]        wb_control_d;
    logic [DEST_W-1:0] wb_dest_d;
    logic [DATA_W-1:0] wb_data_d;

    logic [3:0] ex_op;
    logic       ex_is_mem;
    logic       cap_is_store;
    logic       timeout_hit;

    assign ex_op        = ex_control[3:0];
    assign ex_is_mem    = (ex_op == OP_LOAD) || (ex_op == OP_STORE);
    assign cap_is_store = (cap_ctrl_q[3:0] == OP_STORE);
    assign timeout_hit  = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Stall execute whenever an access is outstanding.
    assign ex_ready = (state_q == S_IDLE);

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cap_dest_q <= '0;
            cap_ctrl_q <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wb_valid   <= 1'b0;
            wb_control <= '0;
            wb_dest    <= '0;
            wb_data    <= '0;
            wb_wr_en   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_dest_q <= cap_dest_d;
            cap_ctrl_q <= cap_ctrl_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            wb_valid   <= wb_valid_d;
            wb_control <= wb_control_d;
            wb_dest    <= wb_dest_d;
            wb_data    <= wb_data_d;
            wb_wr_en   <= wb_wr_en_d;
            bus_err    <= bus_err_d;
        end
    end

    // Next-state and next-output logic; pulses default low, payload holds.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_dest_d   = cap_dest_q;
        cap_ctrl_d   = cap_ctrl_q;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        wb_valid_d   = 1'b0;
        wb_wr_en_d   = 1'b0;
        bus_err_d    = 1'b0;
        wb_control_d = wb_control;
        wb_dest_d    = wb_dest;
        wb_data_d    = wb_data;

        case (state_q)
            S_IDLE: begin
                if (ex_valid && (ex_op != OP_NOP)) begin
                    if (ex_is_mem) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = (ex_op == OP_STORE);
                        mem_addr_d  = ex_result[ADDR_W-1:0];
                        mem_wdata_d = (ex_op == OP_STORE) ? ex_store_data : '0;
                        cap_dest_d  = ex_dest;
                        cap_ctrl_d  = ex_control;
                        cnt_d       = '0;
                        state_d     = S_ACCESS;
                    end else begin
                        wb_valid_d   = 1'b1;
                        wb_data_d    = ex_result;
                        wb_dest_d    = ex_dest;
                        wb_control_d = ex_control;
                        wb_wr_en_d   = ex_wr_en;
                    end
                end
            end

            S_ACCESS: begin
                // Completion takes priority over a coincident timeout.
                if (mem_ready) begin
                    mem_req_d    = 1'b0;
                    wb_valid_d   = 1'b1;
                    wb_dest_d    = cap_dest_q;
                    wb_control_d = cap_ctrl_q;
                    wb_data_d    = cap_is_store ? '0 : mem_rdata;
                    wb_wr_en_d   = !cap_is_store;
                    state_d      = S_IDLE;
                end else if (timeout_hit) begin
                    mem_req_d    = 1'b0;
                    bus_err_d    = 1'b1;
                    wb_valid_d   = 1'b1;
                    wb_dest_d    = cap_dest_q;
                    wb_control_d = cap_ctrl_q;
                    wb_data_d    = '0;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

endmodule
